// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: state encodings,
// default key codes and the digit classifier.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_GET_A  = 3'b001,
    ST_GET_OP = 3'b011,
    ST_GET_B  = 3'b111,
    ST_SHOW_R = 3'b101,
    ST_ERR    = 3'b100
  } state_t;

  localparam logic [3:0] KEY_ADD_CODE = 4'hA;
  localparam logic [3:0] KEY_SUB_CODE = 4'hB;
  localparam logic [3:0] KEY_EQ_CODE  = 4'hF;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes an active-low bouncy key line, debounces it and emits a
// one-cycle pulse on each accepted high-to-low transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1_reg;
  logic             sync_2_reg;
  logic             level_reg;
  logic             level_d_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Idle level of the key line is high, so everything resets to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1_reg  <= 1'b1;
      sync_2_reg  <= 1'b1;
      level_reg   <= 1'b1;
      level_d_reg <= 1'b1;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync_1_reg <= raw;
      sync_2_reg <= sync_1_reg;
      if (sync_2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync_2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
      level_d_reg <= level_reg;
      press_reg   <= level_d_reg & ~level_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/calc_sequencer.sv
// Control unit for the keypad calculator datapath: sequences operand and
// operator entry, chains results back into A and traps ALU overflow.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [3:0] KEY_ADD         = KEY_ADD_CODE,
  parameter logic [3:0] KEY_SUB         = KEY_SUB_CODE,
  parameter logic [3:0] KEY_EQ          = KEY_EQ_CODE
) (
  input  logic       i_CLOCK,
  input  logic       i_CLEAR_ALL,
  input  logic       i_CLEAR_ENTRY,
  input  logic       i_TRIG,
  input  logic [3:0] i_VALUE,
  input  logic       i_OVF,
  output logic       o_reset,
  output logic       o_loadA,
  output logic       o_loadB,
  output logic       o_loadR,
  output logic       o_addSub,
  output logic       o_selR,
  output logic       o_IUAU,
  output logic       o_err,
  output logic [2:0] o_state
);

  logic   press;
  logic   ce_sync_1_reg, ce_sync_2_reg, ce_prev_reg;
  logic   ce_event;

  state_t state_reg, state_next;
  logic   reset_reg, reset_next;
  logic   load_a_reg, load_a_next;
  logic   load_b_reg, load_b_next;
  logic   load_r_reg, load_r_next;
  logic   add_sub_reg, add_sub_next;
  logic   sel_r_reg, sel_r_next;
  logic   iuau_reg, iuau_next;
  logic   err_reg, err_next;
  logic   b_valid_reg, b_valid_next;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig (
    .clk  (i_CLOCK),
    .rst_n(i_CLEAR_ALL),
    .raw  (i_TRIG),
    .press(press)
  );

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_ALL) begin
    if (!i_CLEAR_ALL) begin
      ce_sync_1_reg <= 1'b1;
      ce_sync_2_reg <= 1'b1;
      ce_prev_reg   <= 1'b1;
    end else begin
      ce_sync_1_reg <= i_CLEAR_ENTRY;
      ce_sync_2_reg <= ce_sync_1_reg;
      ce_prev_reg   <= ce_sync_2_reg;
    end
  end

  assign ce_event = ce_prev_reg & ~ce_sync_2_reg;

  always_comb begin
    state_next   = state_reg;
    load_a_next  = 1'b1;
    load_b_next  = 1'b1;
    load_r_next  = 1'b1;
    add_sub_next = add_sub_reg;
    sel_r_next   = sel_r_reg;
    b_valid_next = b_valid_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next   = ST_GET_A;
        b_valid_next = 1'b0;
      end
      ST_GET_A: begin
        if (!ce_event && press && is_digit(i_VALUE)) begin
          load_a_next = 1'b0;
          sel_r_next  = 1'b0;
          state_next  = ST_GET_OP;
        end
      end
      ST_GET_OP: begin
        if (ce_event) begin
          state_next = ST_GET_A;
        end else if (press && (i_VALUE == KEY_ADD || i_VALUE == KEY_SUB)) begin
          add_sub_next = (i_VALUE == KEY_SUB);
          b_valid_next = 1'b0;
          state_next   = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (ce_event) begin
          b_valid_next = 1'b0;
        end else if (press && is_digit(i_VALUE)) begin
          load_b_next  = 1'b0;
          b_valid_next = 1'b1;
        end else if (press && i_VALUE == KEY_EQ && b_valid_reg) begin
          load_r_next = 1'b0;
          state_next  = ST_SHOW_R;
        end
      end
      ST_SHOW_R: begin
        // Overflow is only meaningful while R is being captured.
        if (ce_event) begin
          state_next = ST_IDLE;
        end else if (!load_r_reg && i_OVF) begin
          state_next = ST_ERR;
        end else if (press && (i_VALUE == KEY_ADD || i_VALUE == KEY_SUB)) begin
          load_a_next  = 1'b0;
          sel_r_next   = 1'b1;
          add_sub_next = (i_VALUE == KEY_SUB);
          b_valid_next = 1'b0;
          state_next   = ST_GET_B;
        end else if (press && is_digit(i_VALUE)) begin
          load_a_next = 1'b0;
          sel_r_next  = 1'b0;
          state_next  = ST_GET_OP;
        end
      end
      ST_ERR: begin
        if (ce_event) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    reset_next = (state_next != ST_IDLE);
    iuau_next  = (state_next == ST_SHOW_R) || (state_next == ST_ERR);
    err_next   = (state_next == ST_ERR);
  end

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_ALL) begin
    if (!i_CLEAR_ALL) begin
      state_reg   <= ST_IDLE;
      reset_reg   <= 1'b0;
      load_a_reg  <= 1'b1;
      load_b_reg  <= 1'b1;
      load_r_reg  <= 1'b1;
      add_sub_reg <= 1'b0;
      sel_r_reg   <= 1'b0;
      iuau_reg    <= 1'b0;
      err_reg     <= 1'b0;
      b_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      reset_reg   <= reset_next;
      load_a_reg  <= load_a_next;
      load_b_reg  <= load_b_next;
      load_r_reg  <= load_r_next;
      add_sub_reg <= add_sub_next;
      sel_r_reg   <= sel_r_next;
      iuau_reg    <= iuau_next;
      err_reg     <= err_next;
      b_valid_reg <= b_valid_next;
    end
  end

  assign o_reset  = reset_reg;
  assign o_loadA  = load_a_reg;
  assign o_loadB  = load_b_reg;
  assign o_loadR  = load_r_reg;
  assign o_addSub = add_sub_reg;
  assign o_selR   = sel_r_reg;
  assign o_IUAU   = iuau_reg;
  assign o_err    = err_reg;
  assign o_state  = state_reg;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Synchronous control unit for the lab-12 keypad calculator datapath (A/B operand registers, add/sub ALU, result register R, IU/AU display mux).
- Conditions the raw keypad trigger and turns each key press into a one-cycle event.
- Sequences the operand/operator/equals entry, including chained operations (R fed back into A).
- Drives active-low load strobes and display select, and traps ALU overflow into an error state.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a trigger level change is accepted (minimum 1).
KEY_ADD, 4'hA, keypad code for add.
KEY_SUB, 4'hB, keypad code for subtract.
KEY_EQ, 4'hF, keypad code for equals.

Ports:
i_CLOCK  in  1  system clock; all state on rising edge.
i_CLEAR_ALL  in  1  asynchronous, active-low reset.
i_CLEAR_ENTRY  in  1  active-low clear-entry button, asynchronous to clock.
i_TRIG  in  1  active-low key-press strobe from keypad encoder, asynchronous and bouncy.
i_VALUE  in  4  keypad code; sampled only on a press event.
i_OVF  in  1  ALU overflow for the current operation, valid combinationally from A/B/addSub.
o_reset  out  1  active-low datapath register clear.
o_loadA  out  1  active-low, one-cycle load strobe for A.
o_loadB  out  1  active-low, one-cycle load strobe for B.
o_loadR  out  1  active-low, one-cycle load strobe for R.
o_addSub  out  1  0 = add, 1 = subtract; held between operations.
o_selR  out  1  A input mux: 0 = i_VALUE, 1 = R (chaining); meaningful only while o_loadA is low.
o_IUAU  out  1  display select, 1 = show R.
o_err  out  1  overflow error indicator.
o_state  out  3  current state encoding, for LED debug.

Behaviour:
- Reset while i_CLEAR_ALL is low, taking effect immediately:
  - state = IDLE; o_reset = 0; o_loadA, o_loadB, o_loadR = 1.
  - o_addSub, o_selR, o_IUAU, o_err = 0.
  - Debounce counter and b_valid flag cleared; debounced trigger level = 1.
  - Mid-operation reset abandons any strobe in flight.
- Trigger conditioning:
  - 2-flop synchronizer, then debounce: the accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of a new synchronized value.
  - A press event is a one-cycle pulse on the accepted 1->0 edge.
  - Latency is DEBOUNCE_CYCLES+3 cycles from a stable-low i_TRIG.
  - Release generates no event.
- Clear-entry: 2-flop synchronizer; acts on the synchronized falling edge; takes priority over a press event in the same cycle.
- State encodings: IDLE 000, GET_A 001, GET_OP 011, GET_B 111, SHOW_R 101, ERR 100.
- All strobes are registered outputs, low for exactly one cycle in the cycle after the event.
- IDLE:
  - o_reset low for one cycle, then unconditionally GET_A.
  - o_reset is 1 in every other state.
- GET_A:
  - Press with value 0-9: loadA pulse (selR = 0), go to GET_OP.
  - Any other code: ignored.
  - Clear-entry: stay.
- GET_OP:
  - Press KEY_ADD: addSub = 0, go to GET_B.
  - Press KEY_SUB: addSub = 1, go to GET_B.
  - Others: ignored.
  - Clear-entry: go to GET_A.
- GET_B:
  - Press 0-9: loadB pulse, b_valid = 1, stay (overwrite allowed).
  - Press KEY_EQ with b_valid = 1: loadR pulse, go to SHOW_R.
  - KEY_EQ with b_valid = 0: ignored.
  - Clear-entry: b_valid = 0, stay.
- SHOW_R (o_IUAU = 1):
  - i_OVF is sampled in the cycle the loadR strobe is low; if high, go to ERR next cycle.
  - Press KEY_ADD/KEY_SUB: loadA pulse with selR = 1, addSub updated, b_valid = 0, go to GET_B.
  - Press 0-9: loadA pulse with selR = 0, go to GET_OP.
  - Press KEY_EQ: ignored.
  - Clear-entry: go to IDLE.
- ERR:
  - o_err = 1, o_IUAU = 1.
  - Presses ignored; clear-entry goes to IDLE.
- o_state mirrors the state register. No combinational path from i_TRIG or i_VALUE to any output.

Decomposition:
- Package calc_pkg: state encoding constants, key code constants (KEY_ADD/KEY_SUB/KEY_EQ, digit range 0-9).
- One sub-module, key_debounce (synchronizer + counter + falling-edge pulse, parameter DEBOUNCE_CYCLES), instantiated for i_TRIG.
- Clear-entry uses synchronizer and edge detect only.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4.
1. Release reset -> o_reset low exactly one cycle, then o_state = 001; all loads high throughout.
2. Press 5, A, 3, F -> loadA, loadB, loadR pulses one cycle each, in order; addSub = 0 at loadR; o_state ends 101, o_IUAU = 1.
3. i_TRIG bounce: 3-cycle low glitches, then stable low -> exactly one event, DEBOUNCE_CYCLES+3 cycles after stable low; no event on release.
4. In SHOW_R press B, then 2, then F -> loadA with selR = 1 and addSub = 1, then loadB, then loadR; back in 101.
5. GET_B with F before any digit -> ignored, stays 111; clear-entry after digit 7 then F -> F ignored.
6. i_OVF = 1 during loadR -> ERR (100), o_err = 1, presses ignored. Clear-entry -> IDLE then GET_A. Assert i_CLEAR_ALL mid-sequence -> outputs immediately at reset values.
